// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer handshake for the UART receive FIFO.
// The master is the receiver/host side and the slave is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic              rx_done_tick;
    logic [DBIT-1:0]   rx_dout;
    logic              rd_uart;
    logic              clr_overrun;
    logic [DBIT-1:0]   r_data;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W:0]   rx_count;
    logic              overrun;

    modport master (
        output rx_done_tick, rx_dout, rd_uart, clr_overrun,
        input  r_data, rx_empty, rx_full, rx_count, overrun
    );

    modport slave (
        input  rx_done_tick, rx_dout, rd_uart, clr_overrun,
        output r_data, rx_empty, rx_full, rx_count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART receiver, with occupancy flags.
// Define UART_RX_FIFO_OVERRUN_EN to build the sticky overrun flag.
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_fifo_if.slave   bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop on a full FIFO frees the head slot, so the same-cycle write can land.
    assign wr_en = bus.rx_done_tick && (!full || bus.rd_uart);
    assign rd_en = bus.rd_uart && !empty;

    // NOTE: storage carries no reset; count gates every read, so stale entries are never exposed.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= bus.rx_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.r_data   = empty ? '0 : mem[rd_ptr];
    assign bus.rx_empty = empty;
    assign bus.rx_full  = full;
    assign bus.rx_count = count;

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic drop;
    logic overrun_q;

    assign drop = bus.rx_done_tick && full && !bus.rd_uart;

    // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.overrun = overrun_q;
`else
    logic unused_clr_overrun;

    assign unused_clr_overrun = bus.clr_overrun;
    assign bus.overrun        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; overrun expectations follow UART_RX_FIFO_OVERRUN_EN.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
`ifdef UART_RX_FIFO_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Status packed as {empty, full, count[4:0], r_data[7:0], overrun}.
    function automatic logic [15:0] stat();
        return {bus.rx_empty, bus.rx_full, bus.rx_count, bus.r_data, bus.overrun};
    endfunction

    function automatic logic [15:0] mk(input logic e, input logic f, input logic [4:0] c,
                                       input logic [7:0] d, input logic o);
        return {e, f, c, d, o};
    endfunction

    // One clock with the given strobes, then strobes drop; outputs are sampled 1ns after the edge.
    task automatic tick(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        bus.rx_done_tick = wr;
        bus.rx_dout      = d;
        bus.rd_uart      = rd;
        bus.clr_overrun  = clr;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.rd_uart      = 1'b0;
        bus.clr_overrun  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] s;
        do_reset();
        s = stat();
        checks++;
        if (s !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", s, mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL pop_while_empty: got %h expected %h", s, mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_two_bytes();
        logic [15:0] s;
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd1, 8'hA5, 1'b0)) begin
            errors++;
            $display("FAIL first_write_latency: got %h expected %h", s, mk(1'b0, 1'b0, 5'd1, 8'hA5, 1'b0));
        end
        tick(1'b1, 8'h3C, 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd2, 8'hA5, 1'b0)) begin
            errors++;
            $display("FAIL two_bytes_head: got %h expected %h", s, mk(1'b0, 1'b0, 5'd2, 8'hA5, 1'b0));
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd1, 8'h3C, 1'b0)) begin
            errors++;
            $display("FAIL pop_one: got %h expected %h", s, mk(1'b0, 1'b0, 5'd1, 8'h3C, 1'b0));
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL pop_to_empty: got %h expected %h", s, mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_fill_overrun();
        logic [15:0] s;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b1, 5'd16, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL fill_full: got %h expected %h", s, mk(1'b0, 1'b1, 5'd16, 8'h00, 1'b0));
        end
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b1, 5'd16, 8'h00, OVR)) begin
            errors++;
            $display("FAIL drop_on_full: got %h expected %h", s, mk(1'b0, 1'b1, 5'd16, 8'h00, OVR));
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.r_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h expected %h", i, bus.r_data, 8'(i));
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        s = stat();
        checks++;
        if (s !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL drained_and_cleared: got %h expected %h", s, mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_full_simultaneous();
        logic [15:0] s;
        logic [7:0]  exp;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b1, 5'd16, 8'h01, 1'b0)) begin
            errors++;
            $display("FAIL full_wr_rd: got %h expected %h", s, mk(1'b0, 1'b1, 5'd16, 8'h01, 1'b0));
        end
        for (int i = 1; i <= 16; i++) begin
            exp = (i == 16) ? 8'h55 : 8'(i);
            checks++;
            if (bus.r_data !== exp) begin
                errors++;
                $display("FAIL full_wr_rd_drain[%0d]: got %h expected %h", i, bus.r_data, exp);
            end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (bus.rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_wr_rd_empty: got %b expected 1", bus.rx_empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] exp;
        for (int i = 0; i < 40; i++) begin
            b = 8'((i * 7 + 3) & 255);
            tick(1'b1, b, 1'b0, 1'b0);
            q.push_back(b);
            if (i % 3 == 2 || i == 39) begin
                while (q.size() > 0) begin
                    exp = q.pop_front();
                    checks++;
                    if (bus.r_data !== exp) begin
                        errors++;
                        $display("FAIL wrap_order[%0d]: got %h expected %h", i, bus.r_data, exp);
                    end
                    tick(1'b0, 8'h00, 1'b1, 1'b0);
                end
            end
        end
        checks++;
        if (stat() !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL wrap_end: got %h expected %h", stat(), mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
    endtask

    task automatic test_empty_simultaneous();
        logic [15:0] s;
        tick(1'b1, 8'h9E, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd1, 8'h9E, 1'b0)) begin
            errors++;
            $display("FAIL empty_wr_rd: got %h expected %h", s, mk(1'b0, 1'b0, 5'd1, 8'h9E, 1'b0));
        end
        tick(1'b1, 8'h42, 1'b1, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd1, 8'h42, 1'b0)) begin
            errors++;
            $display("FAIL mid_wr_rd: got %h expected %h", s, mk(1'b0, 1'b0, 5'd1, 8'h42, 1'b0));
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_overrun_clear();
        logic [15:0] s;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        tick(1'b1, 8'hEF, 1'b0, 1'b1);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b1, 5'd16, 8'h80, OVR)) begin
            errors++;
            $display("FAIL set_beats_clear: got %h expected %h", s, mk(1'b0, 1'b1, 5'd16, 8'h80, OVR));
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b1, 5'd16, 8'h80, 1'b0)) begin
            errors++;
            $display("FAIL clear_alone: got %h expected %h", s, mk(1'b0, 1'b1, 5'd16, 8'h80, 1'b0));
        end
        tick(1'b1, 8'hF0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd5, 8'h10, 1'b0)) begin
            errors++;
            $display("FAIL pre_reset_count: got %h expected %h", s, mk(1'b0, 1'b0, 5'd5, 8'h10, 1'b0));
        end
        rst = 1'b1;
        tick(1'b1, 8'hCC, 1'b1, 1'b0);
        rst = 1'b0;
        s = stat();
        checks++;
        if (s !== mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0)) begin
            errors++;
            $display("FAIL reset_priority: got %h expected %h", s, mk(1'b1, 1'b0, 5'd0, 8'h00, 1'b0));
        end
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        s = stat();
        checks++;
        if (s !== mk(1'b0, 1'b0, 5'd1, 8'h77, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_write: got %h expected %h", s, mk(1'b0, 1'b0, 5'd1, 8'h77, 1'b0));
        end
    endtask

    initial begin
        bus.rx_done_tick = 1'b0;
        bus.rx_dout      = 8'h00;
        bus.rd_uart      = 1'b0;
        bus.clr_overrun  = 1'b0;
        test_reset();
        test_two_bytes();
        test_fill_overrun();
        test_full_simultaneous();
        test_wrap();
        test_empty_simultaneous();
        test_overrun_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
